// File: rtl/program_loader.sv
// Byte-to-word program loader: packs UART bytes big-endian into 32-bit
// words and writes them sequentially into the instruction BRAM until the
// halt word is written or the memory is full.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic              o_w_enable,
  output logic [ADDR_W-1:0] o_address,
  output logic [31:0]       o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [31:0]       shift, shift_n;
  logic              w_enable_n;
  logic [ADDR_W-1:0] address_n;
  logic [31:0]       data_n;
  logic [ADDR_W:0]   word_count_n;
  logic              busy_n;
  logic              done_n;

  // Next-state and next-output decode; every output is a flop fed from here.
  always_comb begin
    state_n      = state;
    byte_idx_n   = byte_idx;
    shift_n      = shift;
    w_enable_n   = 1'b0;
    address_n    = o_address;
    data_n       = o_data;
    word_count_n = o_word_count;

    case (state)
      IDLE, DONE: begin
        // Strobes are ignored here; only a start pulse re-arms the loader.
        if (i_start) begin
          state_n      = RECV;
          address_n    = '0;
          word_count_n = '0;
          byte_idx_n   = '0;
          shift_n      = '0;
        end
      end

      RECV: begin
        if (i_rx_done) begin
          shift_n    = {shift[23:0], i_rx_data};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state_n    = WRITE;
            w_enable_n = 1'b1;
            data_n     = shift_n;
          end
        end
      end

      WRITE: begin
        word_count_n = o_word_count + (ADDR_W+1)'(1);
        if ((o_data == HALT_WORD) || (o_address == LAST_ADDR)) begin
          // Terminal write: address is held and a coincident byte is dropped.
          state_n = DONE;
        end else begin
          state_n   = RECV;
          address_n = o_address + ADDR_W'(1);
          // A byte arriving during the write cycle starts the next word.
          if (i_rx_done) begin
            shift_n    = {shift[23:0], i_rx_data};
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RECV) || (state_n == WRITE);
    done_n = (state_n == DONE);
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state        <= IDLE;
      byte_idx     <= '0;
      shift        <= '0;
      o_w_enable   <= 1'b0;
      o_address    <= '0;
      o_data       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_word_count <= '0;
    end else begin
      state        <= state_n;
      byte_idx     <= byte_idx_n;
      shift        <= shift_n;
      o_w_enable   <= w_enable_n;
      o_address    <= address_n;
      o_data       <= data_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
      o_word_count <= word_count_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected BRAM writes,
// a monitor pops and compares each write the DUT issues.
module tb_program_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_start;
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              o_w_enable;
  logic [ADDR_W-1:0] o_address;
  logic [31:0]       o_data;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_word_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  program_loader #(.ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_w_enable   (o_w_enable),
    .o_address    (o_address),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_word_count (o_word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every write the DUT issues must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_w_enable === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", o_address, o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_address !== e.addr || o_data !== e.data) begin
          fails++;
          $display("FAIL write: addr %h data %h, expected addr %h data %h",
                   o_address, o_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // All drive tasks start and end on a falling edge; back-to-back calls give
  // one strobe per cycle.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    i_reset   = 1'b0;
    i_start   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_w_enable", 32'(o_w_enable), 32'd0);
    check("rst_address", 32'(o_address), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_count", 32'(o_word_count), 32'd0);

    // Single word, latency and post-write bookkeeping
    pulse_start();
    check("start_busy", 32'(o_busy), 32'd1);
    push_write(8'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    check("w1_enable", 32'(o_w_enable), 32'd1);
    check("w1_address", 32'(o_address), 32'd0);
    check("w1_data", o_data, 32'h1234_5678);
    @(negedge clk);
    check("w1_count", 32'(o_word_count), 32'd1);
    check("w1_next_addr", 32'(o_address), 32'd1);
    check("w1_busy", 32'(o_busy), 32'd1);
    check("w1_enable_drop", 32'(o_w_enable), 32'd0);
    check("w1_data_held", o_data, 32'h1234_5678);

    // Halt word terminates the load
    do_reset();
    pulse_start();
    push_write(8'd0, 32'h0000_0001);
    push_write(8'd1, 32'hFFFF_FFFF);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    @(negedge clk);
    check("halt_done", 32'(o_done), 32'd1);
    check("halt_busy", 32'(o_busy), 32'd0);
    check("halt_count", 32'(o_word_count), 32'd2);
    check("halt_addr", 32'(o_address), 32'd1);
    send_word(32'hCAFE_BABE);
    idle(3);
    check("halt_done_hold", 32'(o_done), 32'd1);
    check("halt_count_hold", 32'(o_word_count), 32'd2);

    // Restart from DONE
    pulse_start();
    check("restart_done", 32'(o_done), 32'd0);
    check("restart_busy", 32'(o_busy), 32'd1);
    check("restart_addr", 32'(o_address), 32'd0);
    check("restart_count", 32'(o_word_count), 32'd0);

    // Memory full: 256 non-halt words
    do_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      w = 32'h1000_0000 + 32'(i);
      push_write(ADDR_W'(i), w);
      send_word(w);
    end
    check("full_last_addr", 32'(o_address), 32'd255);
    @(negedge clk);
    check("full_done", 32'(o_done), 32'd1);
    check("full_count", 32'(o_word_count), 32'd256);
    check("full_addr_held", 32'(o_address), 32'd255);

    // Reset mid-word discards the partial bytes
    do_reset();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check("midrst_busy", 32'(o_busy), 32'd0);
    pulse_start();
    push_write(8'd0, 32'h0102_0304);
    send_word(32'h0102_0304);
    @(negedge clk);
    check("midrst_count", 32'(o_word_count), 32'd1);

    // Byte coincident with the write cycle becomes the next word's MSB
    do_reset();
    pulse_start();
    push_write(8'd0, 32'hA1A2_A3A4);
    push_write(8'd1, 32'hB1B2_B3B4);
    send_word(32'hA1A2_A3A4);
    send_word(32'hB1B2_B3B4);
    @(negedge clk);
    check("coinc_count", 32'(o_word_count), 32'd2);
    check("coinc_addr", 32'(o_address), 32'd2);

    // Strobes in IDLE and start during RECV are ignored
    do_reset();
    send_word(32'h1122_3344);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_addr", 32'(o_address), 32'd0);
    pulse_start();
    push_write(8'd0, 32'h5566_7788);
    push_write(8'd1, 32'h99AA_BBCC);
    send_word(32'h5566_7788);
    idle(1);
    send_byte(8'h99);
    send_byte(8'hAA);
    pulse_start();
    check("recv_start_busy", 32'(o_busy), 32'd1);
    check("recv_start_addr", 32'(o_address), 32'd1);
    send_byte(8'hBB);
    send_byte(8'hCC);
    @(negedge clk);
    check("recv_start_count", 32'(o_word_count), 32'd2);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the 256 x 32 instruction BRAM.
- Collects bytes from the UART receiver, packs each group of four bytes into a 32-bit word, and issues one single-cycle write per word at sequential addresses starting at 0.
- Loading ends on a programmable halt word or when the memory is full. The debug unit then starts the processor.

Parameters:
- ADDR_W, 8, BRAM address width; capacity is 2^ADDR_W words.
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates loading. The halt word itself is written.

Ports:
- clk  input  1  system clock; all logic on posedge
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  one-cycle pulse; arms loading from address 0
- i_rx_data  input  8  received UART byte
- i_rx_done  input  1  one-cycle strobe; i_rx_data is valid this cycle
- o_w_enable  output  1  BRAM write enable, one cycle per word
- o_address  output  ADDR_W  BRAM write address
- o_data  output  32  BRAM write data
- o_busy  output  1  high in RECV and WRITE
- o_done  output  1  high in DONE
- o_word_count  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset, synchronous and active-high:
  - State goes to IDLE.
  - o_w_enable=0, o_address=0, o_data=0, o_busy=0, o_done=0, o_word_count=0.
  - Byte index and shift register are cleared.
  - A reset mid-load discards any partial word. No write is issued that cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_rx_done is ignored.
  - On i_start: go to RECV; o_address=0, o_word_count=0, byte index=0.
- RECV:
  - Each i_rx_done shifts i_rx_data into the word, first byte as MSB (big-endian): word <= {word[23:0], i_rx_data}.
  - The byte index increments on each strobe.
  - When the strobe carries the 4th byte (index 3), the next cycle is WRITE with:
    - o_data = assembled word
    - o_w_enable = 1
    - o_address = current address
  - Latency: 1 cycle from the 4th i_rx_done to o_w_enable high.
- WRITE, exactly one cycle:
  - o_w_enable and o_data are held; o_address is stable for the whole cycle.
  - o_word_count increments at the end of the cycle.
  - Next state:
    - If o_data == HALT_WORD, or o_address == 2^ADDR_W-1, go to DONE with o_address held.
    - Otherwise go to RECV with o_address+1.
  - An i_rx_done during WRITE is accepted as byte 0 of the next word; it is not lost.
  - If WRITE exits to DONE, that byte is dropped.
- DONE:
  - o_done=1, o_busy=0, o_w_enable=0.
  - i_rx_done is ignored.
  - o_word_count holds its final value.
  - i_start restarts a new load (same as from IDLE); o_done drops the next cycle.
- i_start is ignored in RECV and WRITE.
- o_w_enable is 0 in every state except WRITE.
- o_data keeps its last written value outside WRITE.
- Address wrap: there is no wrap. The write to the last address always terminates the load.

Test Plan:
- Reset, i_start, then bytes 12,34,56,78 -> one cycle after the 4th strobe: o_w_enable=1, o_address=0, o_data=32'h12345678; next cycle o_word_count=1, o_address=1, o_busy=1.
- Two words 00000001, then FFFFFFFF -> writes at address 0 and 1; o_done=1 the cycle after the 2nd write; o_word_count=2; further bytes produce no writes.
- 256 non-halt words with ADDR_W=8 -> last write at address 255, then DONE; o_word_count=256; o_address=255.
- Send 2 bytes AA,BB, assert i_reset, then i_start and bytes 01,02,03,04 -> only write is 32'h01020304 at address 0; no partial AA/BB data appears.
- Strobe coincident with the WRITE cycle of word 0, followed by 3 more bytes -> word 1 uses that byte as its MSB and is written at address 1.
- i_rx_done in IDLE and i_start during RECV -> no state change, no write, address not reset.
